// File: rtl/dff_debounce_edge_pkg.sv
// dff_debounce_edge_pkg: FSM encodings and default qualification length shared by the debounce block
package dff_debounce_edge_pkg;
   localparam logic [0:0] ST_STABLE = 1'b0;
   localparam logic [0:0] ST_CHECK = 1'b1;
   localparam int STABLE_CYCLES_DEF = 8;
endpackage

// File: rtl/dff_debounce_edge_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level, synchronous active-high reset to 0
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic r_s1;
   always_ff @(posedge i_clk)
      if (i_rst) {o_q, r_s1} <= 2'b00;
      else {o_q, r_s1} <= {r_s1, i_d};
endmodule

// File: rtl/dff_debounce_edge.sv
// dff_debounce_edge: synchronise, debounce and edge-strobe a raw level
// DEB_EDGE_CNT_EN adds a wrapping rising-edge counter on o_edge_cnt (otherwise tied to 0)
module dff_debounce_edge
   import dff_debounce_edge_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int EDGE_CNT_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_d,
   output logic                  o_q,
   output logic                  o_rise,
   output logic                  o_fall,
   output logic                  o_busy,
   output logic [EDGE_CNT_W-1:0] o_edge_cnt
);
   localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   logic             w_s2;
   logic             w_diff;
   logic             w_commit;
   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   sync_2ff u_sync (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .o_q(w_s2));
   assign w_diff = w_s2 ^ o_q;
   assign w_commit = (r_state == ST_CHECK) && w_diff && (r_cnt == LAST);
   assign o_busy = (r_state == ST_CHECK);
   // any sample matching o_q drops the candidate and clears the count: no partial credit
   always_ff @(posedge i_clk)
      if (i_rst) begin
         r_state <= ST_STABLE;
         r_cnt <= '0;
         o_q <= 1'b0;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         r_state <= (w_diff && !w_commit) ? ST_CHECK : ST_STABLE;
         r_cnt <= (!w_diff || w_commit) ? '0 : (r_state == ST_STABLE) ? CNT_W'(1) : r_cnt + 1'b1;
         o_q <= o_q ^ w_commit;
         o_rise <= w_commit & w_s2;
         o_fall <= w_commit & ~w_s2;
      end
`ifdef DEB_EDGE_CNT_EN
   logic [EDGE_CNT_W-1:0] r_edge_cnt;
   always_ff @(posedge i_clk)
      if (i_rst) r_edge_cnt <= '0;
      else if (w_commit & w_s2) r_edge_cnt <= r_edge_cnt + 1'b1;
   assign o_edge_cnt = r_edge_cnt;
`else
   assign o_edge_cnt = '0;
`endif
endmodule

// File: tb/tb_dff_debounce_edge.sv
// tb_dff_debounce_edge: directed vectors and cycle-exact sequences for dff_debounce_edge (STABLE_CYCLES=8, EDGE_CNT_W=2)
module tb_dff_debounce_edge;
   typedef struct packed {
      logic d0;
      int   per;
      int   cyc;
      logic eq;
      int   er;
      int   ef;
      logic eb;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       d = 1'b1;
   logic       q, rise, fall, busy;
   logic [1:0] ecnt;
   int         total = 0;
   int         bad = 0;
   int         n_acc = 0;
   int         rise_n, fall_n, both_n;
   vec_t       tbl[15];
   dff_debounce_edge #(.STABLE_CYCLES(8), .EDGE_CNT_W(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_d(d), .o_q(q), .o_rise(rise),
      .o_fall(fall), .o_busy(busy), .o_edge_cnt(ecnt)
   );
   always #5 clk = ~clk;
   function automatic logic [1:0] exp_ec();
`ifdef DEB_EDGE_CNT_EN
      return 2'(n_acc);
`else
      return 2'd0;
`endif
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      rise_n += int'(rise);
      fall_n += int'(fall);
      if (rise && fall) both_n++;
   endtask
   task automatic seq_step(input logic nd);
      d = nd;
      for (int k = 0; k < 11; k++) begin
         tick();
         chk($sformatf("step%0b_edge%0d", nd, k), {28'd0, q, rise, fall, busy},
             {28'd0, (k >= 9) ? nd : ~nd, nd && (k == 9), !nd && (k == 9), (k >= 2 && k <= 8)});
      end
      if (nd) n_acc++;
      chk("step_edge_cnt", {30'd0, ecnt}, {30'd0, exp_ec()});
   endtask
   task automatic hold(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   initial begin
      tbl[0]  = '{1'b1, 0, 7,  1'b0, 0, 0, 1'b1};
      tbl[1]  = '{1'b0, 0, 12, 1'b0, 0, 0, 1'b0};
      tbl[2]  = '{1'b1, 0, 8,  1'b0, 0, 0, 1'b1};
      tbl[3]  = '{1'b0, 0, 12, 1'b0, 1, 1, 1'b0};
      tbl[4]  = '{1'b1, 3, 60, 1'b0, 0, 0, 1'b0};
      tbl[5]  = '{1'b1, 0, 20, 1'b1, 1, 0, 1'b0};
      tbl[6]  = '{1'b0, 0, 20, 1'b0, 0, 1, 1'b0};
      tbl[7]  = '{1'b1, 0, 12, 1'b1, 1, 0, 1'b0};
      tbl[8]  = '{1'b0, 0, 7,  1'b1, 0, 0, 1'b1};
      tbl[9]  = '{1'b1, 0, 12, 1'b1, 0, 0, 1'b0};
      tbl[10] = '{1'b0, 0, 20, 1'b0, 0, 1, 1'b0};
      tbl[11] = '{1'b1, 0, 1,  1'b0, 0, 0, 1'b0};
      tbl[12] = '{1'b0, 0, 12, 1'b0, 0, 0, 1'b0};
      tbl[13] = '{1'b1, 0, 10, 1'b1, 1, 0, 1'b0};
      tbl[14] = '{1'b0, 0, 20, 1'b0, 0, 1, 1'b0};
      rise_n = 0;
      fall_n = 0;
      both_n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("reset_cycle%0d", i), {27'd0, q, rise, fall, busy, ecnt}, 32'd0);
      end
      rst = 1'b0;
      seq_step(1'b1);
      hold(10);
      seq_step(1'b0);
      hold(10);
      seq_step(1'b1);
      hold(10);
      seq_step(1'b0);
      hold(10);
      for (int r = 0; r < 15; r++) begin
         rise_n = 0;
         fall_n = 0;
         both_n = 0;
         for (int c = 0; c < tbl[r].cyc; c++) begin
            d = (tbl[r].per == 0) ? tbl[r].d0 : tbl[r].d0 ^ 1'((c / tbl[r].per) % 2);
            tick();
         end
         n_acc += tbl[r].er;
         chk($sformatf("row%0d_q", r), {31'd0, q}, {31'd0, tbl[r].eq});
         chk($sformatf("row%0d_rises", r), rise_n, tbl[r].er);
         chk($sformatf("row%0d_falls", r), fall_n, tbl[r].ef);
         chk($sformatf("row%0d_busy", r), {31'd0, busy}, {31'd0, tbl[r].eb});
         chk($sformatf("row%0d_overlap", r), both_n, 0);
         chk($sformatf("row%0d_edge_cnt", r), {30'd0, ecnt}, {30'd0, exp_ec()});
      end
      d = 1'b1;
      hold(7);
      chk("midop_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      rise_n = 0;
      fall_n = 0;
      tick();
      chk("midop_after_reset", {28'd0, q, rise, fall, busy}, 32'd0);
      chk("midop_edge_cnt_cleared", {30'd0, ecnt}, 32'd0);
      n_acc = 0;
      rst = 1'b0;
      seq_step(1'b1);
      chk("midop_strobe_count", rise_n + fall_n, 1);
      hold(10);
      seq_step(1'b0);
      hold(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
